dmstorebuf: RTL
===============

# dmstorebuf

Store-side write buffer for the data memory path, the write-direction counterpart of the load-data extender. It sits between the MEM stage and the data memory and turns `sw`/`sh`/`sb` requests into word-aligned memory writes with byte enables and lane-replicated write data. Stores are queued in a small FIFO and drained one per cycle under a memory-ready handshake. The block stalls the pipeline when it is full, or when a load targets a word that still has a pending store.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears the buffer.
- `sop` in 2: store op. 00 none, 01 `sw`, 10 `sh`, 11 `sb`.
- `addr` in 32: store byte address.
- `wdata` in 32: store source register value (rt).
- `ld_req` in 1: a load is in MEM this cycle.
- `ld_addr` in 32: load byte address.
- `stall` out 1: freeze MEM and earlier stages this cycle.
- `st_misalign` out 1: misaligned store exception this cycle.
- `dm_we` out 1: head entry valid; write request to memory.
- `dm_addr` out 32: word address of the head entry, bits [1:0] = 00.
- `dm_be` out 4: byte enables of the head entry; bit i covers bits [8i+7:8i].
- `dm_wdata` out 32: lane-replicated write data of the head entry.
- `dm_ready` in 1: memory accepts the head entry at this clock edge.
- `count` out log2(DEPTH)+1: number of occupied entries.

## Operation
- Alignment check (combinational):
  - `sw` is misaligned when addr[1:0] != 0.
  - `sh` is misaligned when addr[0] = 1.
  - `sb` is never misaligned.
  - A misaligned store sets `st_misalign`=1, is never enqueued and never causes a stall.
- Entry formation for an aligned store:
  - Word address is {addr[31:2],2'b00}.
  - `sw`: be=1111, data=wdata.
  - `sh`: be=0011 if addr[1]=0, else 1100; data={2{wdata[15:0]}}.
  - `sb`: be=0001<<addr[1:0]; data={4{wdata[7:0]}}.
- Enqueue:
  - Condition: `sop`!=0, aligned, `stall`=0.
  - Entry is written at the tail on the rising edge.
- Full:
  - When `count`==DEPTH and an aligned store is presented, `stall`=1 and nothing is enqueued.
  - This holds even if the head retires in the same cycle; there is no full-bypass.
- Load hazard:
  - When `ld_req`=1 and any valid entry has word address == ld_addr[31:2], `stall`=1.
  - Byte enables are ignored; the match is on the whole word.
  - There is no forwarding; the stall holds until the matching entry retires.
- `stall` = full-store condition OR load hazard.
- Drain:
  - When `count`>0: `dm_we`=1 and `dm_addr`/`dm_be`/`dm_wdata` show the head entry.
  - When empty: `dm_we`=0 and the other three outputs are 0.
  - The head retires on an edge where `dm_we`=1 and `dm_ready`=1.
  - Entries retire strictly in FIFO order.
- Simultaneous enqueue and retire: both happen and `count` is unchanged.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Pointers = 0, `count`=0, `dm_we`=0, `dm_addr`/`dm_be`/`dm_wdata`=0.
  - All entries are discarded.
  - `stall`=0 and `st_misalign`=0 while `reset`=1.
- `stall` and `st_misalign` are combinational from the current inputs and buffer state, with no register delay.
- Store latency:
  - A store enqueued at edge T is visible on `dm_*` from cycle T+1 if the buffer was empty.
  - Otherwise it becomes visible after all older entries have retired.
- Throughput: one retire per cycle while `dm_ready`=1, and one enqueue per cycle.
- A load hazard stall clears in the cycle after the edge where the matching entry retires.
- Deassertion of `reset` mid-operation restarts from empty. No partial state survives.

## Test plan
- Byte store lane placement:
  - Stimulus: empty buffer, `dm_ready`=1, `sb` addr=0x00000013, wdata=0x000000AB.
  - Required: next cycle `dm_we`=1, `dm_addr`=0x00000010, `dm_be`=1000, `dm_wdata`=0xABABABAB.
  - Required: one edge later `count`=0.
- Halfword store:
  - Stimulus: `sh` addr=0x22, wdata=0x1234BEEF.
  - Required: `dm_addr`=0x20, `dm_be`=1100, `dm_wdata`=0xBEEFBEEF.
- Fill, stall and ordered drain:
  - Stimulus: `dm_ready`=0, four `sw` to 0x0,0x4,0x8,0xC.
  - Required: `count`=4; a fifth `sw` gives `stall`=1 and `count` stays 4.
  - Stimulus: raise `dm_ready`.
  - Required: addresses 0x0,0x4,0x8,0xC retire on consecutive edges.
- Load hazard:
  - Stimulus: pending `sw` to 0x40 with `dm_ready`=0; `ld_req`=1, ld_addr=0x42.
  - Required: `stall`=1.
  - Stimulus: ld_addr=0x44.
  - Required: `stall`=0.
  - Stimulus: ld_addr back to 0x42, then `dm_ready`=1.
  - Required: `stall` drops the cycle after the entry retires.
- Misalignment and simultaneous events:
  - Stimulus: `sh` addr=0x01.
  - Required: `st_misalign`=1, `stall`=0, `count` unchanged.
  - Stimulus: at `count`=2, an aligned `sw` in the same cycle as a head retire.
  - Required: `count` stays 2.
- Reset mid-operation:
  - Stimulus: 3 entries queued; assert `reset` between clock edges.
  - Required: immediately `count`=0, `dm_we`=0, `dm_*`=0.
  - Required: after release, the next store appears alone on `dm_*`.

Source files
------------

// File: rtl/dmstorebuf.sv
// dmstorebuf: store-side write buffer between MEM and data memory.
// Forms word-aligned writes with byte enables and lane-replicated data,
// queues them in a small FIFO and drains one per cycle under dm_ready.
module dmstorebuf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               sop,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    output logic                     stall,
    output logic                     st_misalign,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [3:0]               dm_be,
    output logic [31:0]              dm_wdata,
    input  logic                     dm_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [29:0]      ent_addr [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [AW-1:0]    head, tail;

    logic        mis_raw;
    logic [3:0]  new_be;
    logic [31:0] new_data;
    logic        is_store;
    logic        full;
    logic        hazard;
    logic        enq;
    logic        deq;

    // Alignment check and entry formation for the incoming store.
    always_comb begin
        mis_raw  = 1'b0;
        new_be   = 4'b0000;
        new_data = 32'h0;
        case (sop)
            2'b01: begin
                mis_raw  = (addr[1:0] != 2'b00);
                new_be   = 4'b1111;
                new_data = wdata;
            end
            2'b10: begin
                mis_raw  = addr[0];
                new_be   = addr[1] ? 4'b1100 : 4'b0011;
                new_data = {2{wdata[15:0]}};
            end
            2'b11: begin
                new_be   = 4'b0001 << addr[1:0];
                new_data = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Word-granular match of the load against every pending entry.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == ld_addr[31:2])) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & ld_req;
    end

    // Stall, exception and handshake decode; no bypass when full.
    always_comb begin
        is_store    = (sop != 2'b00) && !mis_raw;
        full        = (count == CW'(DEPTH));
        stall       = !reset && ((is_store && full) || hazard);
        st_misalign = !reset && mis_raw;
        enq         = is_store && !stall;
        dm_we       = (count != '0);
        deq         = dm_we && dm_ready;
        dm_addr     = dm_we ? {ent_addr[head], 2'b00} : 32'h0;
        dm_be       = dm_we ? ent_be[head] : 4'b0000;
        dm_wdata    = dm_we ? ent_data[head] : 32'h0;
    end

    // Pointers, occupancy and valid flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (enq) begin
                tail          <= tail + 1'b1;
                ent_vld[tail] <= 1'b1;
            end
            if (deq) begin
                head          <= head + 1'b1;
                ent_vld[head] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_be[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else if (enq) begin
            ent_addr[tail] <= addr[31:2];
            ent_be[tail]   <= new_be;
            ent_data[tail] <= new_data;
        end
    end

endmodule
